audio_dma: RTL and testbench
============================

# audio_dma

Bus-master DMA that keeps the sigma-delta audio playback buffer fed from system RAM. It sits directly upstream of the audio block. On the audio half-buffer interrupt, or on a software kick, it copies one half-buffer of 32-bit words from a circular source region in RAM into the audio buffer RAM. It does this over the PicoRV32 native memory bus, and exposes a small register slave for the CPU.

## Interface
- HALF_WORDS, 1024: words per half of the audio buffer (buffer is 2×HALF_WORDS words).
- BUF_BASE, 32'h0: bus byte address of audio buffer word 0.
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  slave select (address decode) for register window.
- mem_valid  in  1  slave request valid.
- mem_ready  out  1  slave ack, one-cycle pulse.
- mem_wstrb  in  4  slave byte write strobes (0 = read).
- mem_wdata  in  32  slave write data.
- mem_addr  in  32  slave address; only [3:2] decoded.
- mem_rdata  out  32  slave read data; 0 when enable low.
- m_valid  out  1  master request valid.
- m_ready  in  1  master ack.
- m_addr  out  32  master byte address, word aligned.
- m_wstrb  out  4  4'h0 on read, 4'hF on write.
- m_wdata  out  32  master write data.
- m_rdata  in  32  master read data, sampled when m_valid&m_ready.
- trig_i  in  1  audio half-buffer interrupt; level, held many cycles.
- irq_o  out  1  transfer-done interrupt, level.

## Operation
- Registers, selected by mem_addr[3:2]:
  - 0 CTRL: [0] EN; [1] KICK (write-1 starts a transfer, reads 0); [2] KHALF (half filled by KICK); [3] IRQEN.
  - 1 SRC_BASE: byte address; [1:0] forced 0.
  - 2 SRC_LEN: [15:0] ring length in words; 0 means 65536.
  - 3 STATUS: [0] BUSY (RO); [1] OVR (W1C); [2] DONE (W1C); [31:16] OFF (current source word offset, RO).
- Register writes honour byte strobes. Writing SRC_BASE or SRC_LEN clears OFF to 0.
- Triggers (ignored while EN=0):
  - Rising edge of trig_i (registered edge detect) fills lower half, words 0..HALF_WORDS-1.
  - KICK fills the half given by KHALF.
  - If both occur on the same cycle, trig_i wins and KICK sets OVR.
  - Any trigger while BUSY sets OVR and is dropped.
- FSM: IDLE → RD → GAP1 → WR → GAP2 → RD … → DONE → IDLE.
  - RD: m_valid=1, m_wstrb=0, m_addr=SRC_BASE+(OFF<<2). On m_ready, latch m_rdata.
  - WR: m_valid=1, m_wstrb=F, m_addr=BUF_BASE+((half·HALF_WORDS+CNT)<<2), m_wdata=latched word. On m_ready, CNT+1 and OFF+1; OFF wraps to 0 when OFF+1==SRC_LEN (16-bit).
  - GAP1/GAP2: m_valid=0 for exactly one cycle. This is required because downstream ready stays high one cycle after valid drops.
  - After the write with CNT==HALF_WORDS-1: go to DONE, set STATUS.DONE, clear BUSY, go to IDLE.
- EN cleared mid-transfer: the in-flight bus request completes (valid is never withdrawn before ready), then FSM goes to IDLE without setting DONE. OFF keeps its advanced value.
- irq_o = DONE & IRQEN.

## Timing
- Reset values: all registers 0, FSM IDLE, m_valid=0, m_addr=0, m_wstrb=0, m_wdata=0, mem_ready=0, mem_rdata=0, irq_o=0, trig edge detector primed to 0.
  - A trig_i already high at reset release counts as an edge once EN=1 and trig_i is seen low→high. A level high at reset release does not fire.
- Slave: mem_ready pulses the cycle after mem_valid&enable, for one cycle. The master must drop mem_valid after ready. rdata is registered with ready.
- Trigger to first m_valid: 2 cycles (edge register, then RD).
- Per word, with zero-wait m_ready: 4 cycles (RD, GAP1, WR, GAP2). Half-buffer of 1024 words takes ≥4096 cycles, well inside the 1024×16-cycle half-period.
- DONE is visible in STATUS and on irq_o the cycle after the final write handshake.
- Synchronous reset mid-transfer: m_valid drops on the next edge. No completion is owed.

## Test plan
- Reset → all outputs 0. Read STATUS → 0, read CTRL → 0.
- SRC_BASE=0x1000, SRC_LEN=8, EN|IRQEN, pulse trig_i high 50 cycles → 1024 reads cycling through 0x1000..0x101C, 1024 writes to BUF_BASE+0..0xFFC with matching data. One transfer only. irq_o=1, OFF=0 (1024 mod 8).
- KICK with KHALF=1 → writes to BUF_BASE+0x1000..0x1FFC. Second trig_i edge during BUSY → OVR=1, only one transfer. W1C OVR → 0.
- m_ready delayed 3 cycles each → m_valid and m_addr stable until ack. Exactly one idle cycle between requests. Never two handshakes per request.
- Clear EN after 10 writes → in-flight request completes, FSM IDLE, DONE=0, OFF=10.
- Assert resetn=0 while m_valid=1 → m_valid=0 next cycle, STATUS=0.

Source files
------------

// File: rtl/audio_dma.sv
// audio_dma: on an audio half-buffer trigger or a software kick, copies one
// half of the playback buffer from a circular source region in system RAM
// into the audio buffer RAM over the PicoRV32 native bus. A four-register
// slave window gives the CPU control and status.
module audio_dma #(
  parameter int unsigned HALF_WORDS = 1024,
  parameter logic [31:0] BUF_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        trig_i,
  output logic        irq_o
);
  localparam int CW = (HALF_WORDS > 1) ? $clog2(HALF_WORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP1, S_WR, S_GAP2, S_DONE} state_t;
  state_t state_reg;

  logic          en_reg, khalf_reg, irqen_reg, ovr_reg, done_reg;
  logic [31:0]   src_base_reg;
  logic [15:0]   src_len_reg, off_reg;
  logic [CW-1:0] cnt_reg;
  logic          half_reg;
  logic [31:0]   data_reg;
  logic          trig_d_reg, edge_reg, kick_reg;

  logic        busy, slv_acc, slv_wr, src_wr, trig_fire, kick_fire, start;
  logic [15:0] off_inc, off_adv;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign busy      = (state_reg == S_RD) || (state_reg == S_GAP1) ||
                     (state_reg == S_WR) || (state_reg == S_GAP2);
  // A request is taken once; the cycle carrying ready is not a new request.
  assign slv_acc   = mem_valid & enable & ~mem_ready;
  assign slv_wr    = slv_acc & (|mem_wstrb);
  assign src_wr    = slv_wr & ((mem_addr[3:2] == 2'd1) || (mem_addr[3:2] == 2'd2));
  assign trig_fire = edge_reg & en_reg;
  assign kick_fire = kick_reg & en_reg;
  assign start     = ~busy & (trig_fire | kick_fire);
  // Ring wrap; SRC_LEN==0 wraps naturally at the 16-bit overflow.
  assign off_inc   = off_reg + 16'd1;
  assign off_adv   = (off_inc == src_len_reg) ? 16'd0 : off_inc;
  assign irq_o     = done_reg & irqen_reg;
  assign unused_ok = &{1'b0, mem_addr[31:4], mem_addr[1:0]};

  function automatic logic [31:0] src_addr(input logic [31:0] base, input logic [15:0] off);
    return base + {14'd0, off, 2'b00};
  endfunction

  function automatic logic [31:0] buf_addr(input logic h, input logic [CW-1:0] c);
    return BUF_BASE + ((32'(h) * HALF_WORDS + 32'(c)) << 2);
  endfunction

  // Register read mux for the slave window.
  always_comb begin
    rd_word = 32'd0;
    case (mem_addr[3:2])
      2'd0: rd_word = {28'd0, irqen_reg, khalf_reg, 1'b0, en_reg};
      2'd1: rd_word = src_base_reg;
      2'd2: rd_word = {16'd0, src_len_reg};
      default: rd_word = {off_reg, 13'd0, done_reg, ovr_reg, busy};
    endcase
  end

  // Slave registers, trigger detection and the copy FSM; later assignments
  // give status sets priority over same-cycle W1C and give SRC writes
  // priority over the FSM's offset advance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      en_reg       <= 1'b0;
      khalf_reg    <= 1'b0;
      irqen_reg    <= 1'b0;
      ovr_reg      <= 1'b0;
      done_reg     <= 1'b0;
      src_base_reg <= 32'd0;
      src_len_reg  <= 16'd0;
      off_reg      <= 16'd0;
      cnt_reg      <= '0;
      half_reg     <= 1'b0;
      data_reg     <= 32'd0;
      trig_d_reg   <= 1'b0;
      edge_reg     <= 1'b0;
      kick_reg     <= 1'b0;
      mem_ready    <= 1'b0;
      mem_rdata    <= 32'd0;
      m_valid      <= 1'b0;
      m_addr       <= 32'd0;
      m_wstrb      <= 4'h0;
      m_wdata      <= 32'd0;
    end else begin
      trig_d_reg <= trig_i;
      edge_reg   <= trig_i & ~trig_d_reg;
      kick_reg   <= 1'b0;
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'd0;

      if (slv_acc) begin
        mem_ready <= 1'b1;
        mem_rdata <= rd_word;
      end
      if (slv_wr) begin
        case (mem_addr[3:2])
          2'd0: if (mem_wstrb[0]) begin
            en_reg    <= mem_wdata[0];
            kick_reg  <= mem_wdata[1];
            khalf_reg <= mem_wdata[2];
            irqen_reg <= mem_wdata[3];
          end
          2'd1: begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) src_base_reg[8*b +: 8] <= mem_wdata[8*b +: 8];
            src_base_reg[1:0] <= 2'b00;
            off_reg           <= 16'd0;
          end
          2'd2: begin
            for (int b = 0; b < 2; b++)
              if (mem_wstrb[b]) src_len_reg[8*b +: 8] <= mem_wdata[8*b +: 8];
            off_reg <= 16'd0;
          end
          default: if (mem_wstrb[0]) begin
            if (mem_wdata[1]) ovr_reg  <= 1'b0;
            if (mem_wdata[2]) done_reg <= 1'b0;
          end
        endcase
      end

      case (state_reg)
        S_IDLE, S_DONE: begin
          state_reg <= S_IDLE;
          if (start) begin
            state_reg <= S_RD;
            half_reg  <= trig_fire ? 1'b0 : khalf_reg;
            cnt_reg   <= '0;
            m_valid   <= 1'b1;
            m_wstrb   <= 4'h0;
            m_addr    <= src_addr(src_base_reg, off_reg);
          end
        end
        S_RD: if (m_ready) begin
          data_reg  <= m_rdata;
          m_valid   <= 1'b0;
          state_reg <= en_reg ? S_GAP1 : S_IDLE;
        end
        S_GAP1: begin
          if (!en_reg) begin
            state_reg <= S_IDLE;
          end else begin
            state_reg <= S_WR;
            m_valid   <= 1'b1;
            m_wstrb   <= 4'hF;
            m_addr    <= buf_addr(half_reg, cnt_reg);
            m_wdata   <= data_reg;
          end
        end
        S_WR: if (m_ready) begin
          m_valid <= 1'b0;
          m_wstrb <= 4'h0;
          cnt_reg <= cnt_reg + 1'b1;
          if (!src_wr) off_reg <= off_adv;
          if (cnt_reg == CNT_LAST) begin
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            state_reg <= en_reg ? S_GAP2 : S_IDLE;
          end
        end
        S_GAP2: begin
          if (!en_reg) begin
            state_reg <= S_IDLE;
          end else begin
            state_reg <= S_RD;
            m_valid   <= 1'b1;
            m_wstrb   <= 4'h0;
            m_addr    <= src_addr(src_base_reg, off_reg);
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      if ((busy && (trig_fire || kick_fire)) || (trig_fire && kick_fire))
        ovr_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_audio_dma.sv
// tb_audio_dma: drives the register slave and a randomly stalling memory
// responder; every master beat is compared against a transfer-level model.
module tb_audio_dma;
  localparam int          HW = 1024;
  localparam logic [31:0] BB = 32'h0;

  logic        clk = 1'b0;
  logic        resetn, enable, mem_valid, mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        trig_i, irq_o;

  always #5 clk = ~clk;

  audio_dma #(.HALF_WORDS(HW), .BUF_BASE(BB)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .trig_i(trig_i), .irq_o(irq_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t exp_q[$];

  logic [31:0] seed;
  logic [31:0] m_src;
  int          m_len, m_off;
  int          rd_cnt = 0, wr_cnt = 0, lat_mode = 0;
  bit          hold = 1'b0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  // One half-buffer copy: read ring word, write it to the next buffer slot.
  task automatic model_transfer(input int half);
    int len;
    len = (m_len == 0) ? 65536 : m_len;
    for (int i = 0; i < HW; i++) begin
      txn_t t;
      logic [31:0] ra;
      ra = m_src + 32'(((m_off + i) % len) * 4);
      t.we = 1'b0; t.addr = ra; t.data = 32'd0;
      exp_q.push_back(t);
      t.we = 1'b1; t.addr = BB + 32'((half * HW + i) * 4); t.data = src_word(ra);
      exp_q.push_back(t);
    end
    m_off = (m_off + HW) % len;
  endtask

  // Memory responder: optional wait states, one-cycle ready per request.
  logic [31:0] cap_addr;
  bit          pending = 1'b0;
  int          wait_left = 0;
  initial begin
    txn_t e;
    m_ready = 1'b0;
    m_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_ready = 1'b0;
        pending = 1'b0;
      end else if (m_ready) begin
        m_ready = 1'b0;
        pending = 1'b0;
        check_eq("gap", 32'(m_valid), 32'd0);
      end else if (m_valid) begin
        if (!pending) begin
          pending   = 1'b1;
          cap_addr  = m_addr;
          wait_left = (lat_mode == 0) ? 0 : (lat_mode == 1) ? int'($urandom_range(3, 0)) : 3;
        end else begin
          check_eq("stable", m_addr, cap_addr);
        end
        if (wait_left > 0) begin
          wait_left--;
        end else if (!hold) begin
          check_eq("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.we) begin
              check_eq("wr_strb", 32'(m_wstrb), 32'hF);
              check_eq("wr_addr", m_addr, e.addr);
              check_eq("wr_data", m_wdata, e.data);
              wr_cnt++;
            end else begin
              check_eq("rd_strb", 32'(m_wstrb), 32'h0);
              check_eq("rd_addr", m_addr, e.addr);
              rd_cnt++;
            end
          end
          m_rdata = (m_wstrb == 4'h0) ? src_word(m_addr) : 32'hDEADBEEF;
          m_ready = 1'b1;
        end
      end
    end
  end

  task automatic bus_xfer(input logic [1:0] idx, input logic [3:0] strb,
                          input logic [31:0] wd, output logic [31:0] rd);
    int n;
    @(negedge clk);
    enable = 1'b1; mem_valid = 1'b1; mem_addr = {28'd0, idx, 2'b00};
    mem_wstrb = strb; mem_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 10);
    check_eq("slv_ready", 32'(mem_ready), 32'd1);
    rd = mem_rdata;
    mem_valid = 1'b0; enable = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk);
    check_eq("slv_pulse", 32'(mem_ready), 32'd0);
    $display("reg %s idx=%0d strb=%h wdata=%h rdata=%h",
             (strb == 4'h0) ? "rd" : "wr", idx, strb, wd, rd);
  endtask

  task automatic reg_write(input logic [1:0] idx, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] dummy;
    bus_xfer(idx, strb, wd, dummy);
  endtask

  task automatic reg_expect(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    bus_xfer(idx, 4'h0, 32'd0, d);
    check_eq(tag, d, exp);
  endtask

  task automatic pulse_trig(input int n);
    @(negedge clk);
    trig_i = 1'b1;
    repeat (n) @(negedge clk);
    trig_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(posedge clk);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int rd0, wr0;
    resetn = 1'b0; enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
    mem_wdata = 32'd0; mem_addr = 32'd0; trig_i = 1'b0;
    seed = $urandom(); m_src = 32'd0; m_len = 0; m_off = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    check_eq("rst_m_wstrb", 32'(m_wstrb), 32'd0);
    check_eq("rst_m_wdata", m_wdata, 32'd0);
    check_eq("rst_mem_ready", 32'(mem_ready), 32'd0);
    check_eq("rst_mem_rdata", mem_rdata, 32'd0);
    check_eq("rst_irq", 32'(irq_o), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    reg_expect("rst_status", 2'd3, 32'd0);
    reg_expect("rst_ctrl", 2'd0, 32'd0);

    // Trigger with EN=0 must be ignored.
    pulse_trig(20);
    repeat (10) @(posedge clk);
    reg_expect("en0_status", 2'd3, 32'd0);

    // Lower half by trig_i, ring of 8 words, zero-wait bus.
    lat_mode = 0;
    reg_write(2'd1, 32'h1000, 4'hF);
    reg_write(2'd2, 32'd8, 4'hF);
    m_src = 32'h1000; m_len = 8; m_off = 0;
    reg_write(2'd0, 32'h9, 4'hF);
    model_transfer(0);
    rd0 = rd_cnt; wr0 = wr_cnt;
    pulse_trig(50);
    drain("t1_drain", 20000);
    repeat (100) @(posedge clk);
    check_eq("t1_reads", 32'(rd_cnt - rd0), 32'(HW));
    check_eq("t1_writes", 32'(wr_cnt - wr0), 32'(HW));
    check_eq("t1_irq", 32'(irq_o), 32'd1);
    reg_expect("t1_status", 2'd3, {16'(m_off), 16'h0004});
    reg_write(2'd3, 32'h4, 4'h1);
    check_eq("t1_irq_clr", 32'(irq_o), 32'd0);
    $display("xfer 1 done reads=%0d writes=%0d", rd_cnt - rd0, wr_cnt - wr0);

    // Upper half by KICK, random wait states, second edge while busy.
    lat_mode = 1;
    model_transfer(1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    reg_write(2'd0, 32'hF, 4'hF);
    repeat (200) @(posedge clk);
    pulse_trig(20);
    drain("t2_drain", 20000);
    repeat (100) @(posedge clk);
    check_eq("t2_writes", 32'(wr_cnt - wr0), 32'(HW));
    reg_expect("t2_status", 2'd3, {16'(m_off), 16'h0006});
    reg_expect("t2_ctrl", 2'd0, 32'hD);
    reg_write(2'd3, 32'h2, 4'h1);
    reg_expect("t2_ovr_clr", 2'd3, {16'(m_off), 16'h0004});
    reg_write(2'd3, 32'h4, 4'h1);
    reg_expect("t2_done_clr", 2'd3, 32'd0);
    $display("xfer 2 done reads=%0d writes=%0d", rd_cnt - rd0, wr_cnt - wr0);

    // Byte strobes on SRC_BASE / SRC_LEN.
    reg_write(2'd1, 32'hAABBCCDF, 4'b0011);
    reg_expect("strb_base", 2'd1, 32'h0000CCDC);
    reg_write(2'd2, 32'h00000300, 4'b0010);
    reg_expect("strb_len", 2'd2, 32'h00000308);

    // Three wait states per beat, ring of 7 words leaves OFF non-zero.
    lat_mode = 2;
    reg_write(2'd1, 32'h2000, 4'hF);
    reg_write(2'd2, 32'd7, 4'hF);
    m_src = 32'h2000; m_len = 7; m_off = 0;
    model_transfer(0);
    pulse_trig(30);
    drain("t3_drain", 30000);
    reg_expect("t3_status", 2'd3, {16'(m_off), 16'h0004});
    reg_write(2'd3, 32'h4, 4'h1);
    reg_write(2'd2, 32'd100, 4'hF);
    m_len = 100; m_off = 0;
    reg_expect("t3_off_clr", 2'd3, 32'd0);
    $display("xfer 3 done off_after=%0d", 1024 % 7);

    // EN cleared after 10 writes: stall the next read across the CTRL write.
    lat_mode = 0;
    wr0 = wr_cnt;
    model_transfer(0);
    reg_write(2'd0, 32'hB, 4'hF);
    for (int c = 0; c < 2000 && wr_cnt < wr0 + 10; c++) @(posedge clk);
    hold = 1'b1;
    reg_write(2'd0, 32'h8, 4'h1);
    hold = 1'b0;
    repeat (20) @(posedge clk);
    check_eq("t4_writes", 32'(wr_cnt - wr0), 32'd10);
    check_eq("t4_valid", 32'(m_valid), 32'd0);
    reg_expect("t4_status", 2'd3, 32'h000A0000);
    exp_q.delete();
    $display("xfer 4 aborted writes=%0d", wr_cnt - wr0);

    // Reset while a request is outstanding.
    hold = 1'b1;
    model_transfer(0);
    reg_write(2'd0, 32'hB, 4'hF);
    for (int c = 0; c < 50 && !m_valid; c++) @(negedge clk);
    check_eq("t5_pre_valid", 32'(m_valid), 32'd1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_valid", 32'(m_valid), 32'd0);
    check_eq("t5_addr", m_addr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    hold = 1'b0;
    reg_expect("t5_status", 2'd3, 32'd0);
    reg_expect("t5_ctrl", 2'd0, 32'd0);
    $display("xfer 5 reset mid-transfer");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
